// File: rtl/secuenciador_rom_if.sv
// Purpose : valid/ready stream carrying fetched ROM words to the downstream consumer.
// Latency : none, this is wiring only.
// Backpressure: the slave holds listo low to stall the master, which then keeps instr and valido stable.
//
// Signals:
//   instr  [7:0]  ROM word, driven by the master
//   valido        instr is valid, driven by the master
//   listo         consumer ready, driven by the slave
interface secuenciador_rom_if;
  logic [7:0] instr;
  logic       valido;
  logic       listo;

  modport master (
    output instr,
    output valido,
    input  listo
  );

  modport slave (
    input  instr,
    input  valido,
    output listo
  );
endinterface

// File: rtl/secuenciador_rom.sv
// Purpose : address sequencer and fetch stage placed in front of an asynchronous ROM, with jump support.
// Latency : 2 cycles from inicio, or from a handshake, to the next valido. Peak throughput is 1 word per 2 cycles.
// Backpressure: ENTREGA waits on listo with no timeout, holding instr and direccion stable.
//
// Ports:
//   clk, rst_n       clock and synchronous active-low reset
//   inicio           start request, only honoured while idle
//   salto_en/_dir    jump request and target, only honoured on the accepting handshake
//   dato_s           combinational ROM word for the current direccion
//   direccion        registered ROM address
//   ocupado          busy, meaning any state other than REPOSO
//   fin              one-cycle pulse when the DIR_FIN word is accepted
//   error            sticky out-of-range jump flag, cleared by inicio or by reset
//   sal              downstream stream (instr / valido / listo)
module secuenciador_rom #(
  parameter logic [7:0] DIR_INICIO = 8'd0,
  parameter logic [7:0] DIR_FIN    = 8'd10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      inicio,
  input  logic                      salto_en,
  input  logic [7:0]                salto_dir,
  input  logic [7:0]                dato_s,
  output logic [7:0]                direccion,
  output logic                      ocupado,
  output logic                      fin,
  output logic                      error,
  secuenciador_rom_if.master        sal
);

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    LEER    = 2'd1,
    ENTREGA = 2'd2
  } estado_t;

  estado_t estado;

  // Jump targets beyond the populated range are rejected rather than fetched.
  logic salto_valido;
  assign salto_valido = (salto_dir <= DIR_FIN);

  // valido is only ever high in ENTREGA, so listo alone is the handshake there.
  logic handshake;
  assign handshake = (estado == ENTREGA) && sal.listo;

  assign ocupado = (estado != REPOSO);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado     <= REPOSO;
      direccion  <= DIR_INICIO;
      sal.instr  <= 8'h00;
      sal.valido <= 1'b0;
      fin        <= 1'b0;
      error      <= 1'b0;
    end else begin
      // fin is a pulse. It defaults low and is raised only on the final acceptance.
      fin <= 1'b0;

      case (estado)
        REPOSO: begin
          if (inicio) begin
            direccion <= DIR_INICIO;
            error     <= 1'b0;
            estado    <= LEER;
          end
        end

        // direccion has been stable since the previous edge, so dato_s has settled.
        LEER: begin
          sal.instr  <= dato_s;
          sal.valido <= 1'b1;
          estado     <= ENTREGA;
        end

        ENTREGA: begin
          if (handshake) begin
            sal.valido <= 1'b0;
            // A jump takes priority over end-of-range, so a jump on the DIR_FIN word raises no fin.
            if (salto_en) begin
              if (salto_valido) begin
                direccion <= salto_dir;
                estado    <= LEER;
              end else begin
                error  <= 1'b1;
                estado <= REPOSO;
              end
            end else if (direccion == DIR_FIN) begin
              fin    <= 1'b1;
              estado <= REPOSO;
            end else begin
              direccion <= direccion + 8'd1;
              estado    <= LEER;
            end
          end
        end

        default: begin
          sal.valido <= 1'b0;
          estado     <= REPOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_rom.sv
// Bench for secuenciador_rom: a random ROM image, and a transaction-level model that tracks which address should be presented next.
module tb_secuenciador_rom;

  localparam logic [7:0] DIR_INICIO = 8'd0;
  localparam logic [7:0] DIR_FIN    = 8'd10;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       inicio    = 1'b0;
  logic       salto_en  = 1'b0;
  logic [7:0] salto_dir = 8'd0;
  logic [7:0] dato_s;
  logic [7:0] direccion;
  logic       ocupado;
  logic       fin;
  logic       error;

  logic [7:0] rom_mem [256];

  secuenciador_rom_if bus ();

  assign dato_s = rom_mem[direccion];

  secuenciador_rom #(
    .DIR_INICIO (DIR_INICIO),
    .DIR_FIN    (DIR_FIN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inicio    (inicio),
    .salto_en  (salto_en),
    .salto_dir (salto_dir),
    .dato_s    (dato_s),
    .direccion (direccion),
    .ocupado   (ocupado),
    .fin       (fin),
    .error     (error),
    .sal       (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Issue inicio from idle. Returns the first address the model expects to see.
  task automatic start_seq(output logic [7:0] a);
    @(negedge clk);
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    check("start_ocupado", 32'(ocupado), 32'(1'b1));
    check("start_dir", 32'(direccion), 32'(DIR_INICIO));
    check("start_err_clr", 32'(error), 32'(1'b0));
    check("start_vld_lo", 32'(bus.valido), 32'(1'b0));
    a = DIR_INICIO;
  endtask

  // One sequence from inicio to fin, error or reset.
  task automatic run_seq(input int stall_at, input int stall_len, input int jump_at,
                         input int jump_to, input int reset_at, input bit rnd);
    logic [7:0] a;
    logic [7:0] j_to;
    bit         do_j;
    bit         jumped;
    int         words;
    int         n;
    int         stalls;
    jumped = 1'b0;
    words  = 0;
    start_seq(a);
    forever begin
      // The next valido must rise exactly 2 edges after the trigger edge.
      n = 1;
      while (bus.valido !== 1'b1 && n < 8) begin
        @(negedge clk);
        inicio = 1'b0;
        n++;
      end
      check("latency", 32'(n), 32'd2);
      if (bus.valido !== 1'b1) return;
      check("dir", 32'(direccion), 32'(a));
      check("instr", 32'(bus.instr), 32'(rom_mem[a]));
      check("ocupado_hi", 32'(ocupado), 32'(1'b1));
      check("fin_lo", 32'(fin), 32'(1'b0));
      words++;

      if (int'(a) == reset_at) begin
        rst_n = 1'b0;
        inicio = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        inicio = 1'b0;
        check("rst_vld", 32'(bus.valido), 32'(1'b0));
        check("rst_instr", 32'(bus.instr), 32'h0);
        check("rst_dir", 32'(direccion), 32'(DIR_INICIO));
        check("rst_ocupado", 32'(ocupado), 32'(1'b0));
        check("rst_fin", 32'(fin), 32'(1'b0));
        check("rst_err", 32'(error), 32'(1'b0));
        repeat (3) begin
          @(negedge clk);
          check("rst_idle", 32'(ocupado), 32'(1'b0));
        end
        return;
      end

      if (int'(a) == stall_at) stalls = stall_len;
      else if (rnd && ($urandom % 4 == 0)) stalls = $urandom_range(1, 4);
      else stalls = 0;
      // While stalled, inicio and salto_en must be ignored.
      for (int i = 0; i < stalls; i++) begin
        bus.listo = 1'b0;
        inicio    = rnd ? 1'($urandom % 2) : 1'b0;
        salto_en  = rnd ? 1'($urandom % 2) : 1'b0;
        salto_dir = 8'($urandom);
        @(negedge clk);
        check("stall_vld", 32'(bus.valido), 32'(1'b1));
        check("stall_instr", 32'(bus.instr), 32'(rom_mem[a]));
        check("stall_dir", 32'(direccion), 32'(a));
      end

      do_j = 1'b0;
      j_to = 8'd0;
      if (int'(a) == jump_at && !jumped) begin
        do_j   = 1'b1;
        j_to   = 8'(jump_to);
        jumped = 1'b1;
      end else if (rnd && words < 25 && ($urandom % 4 == 0)) begin
        do_j = 1'b1;
        if ($urandom % 4 == 0) j_to = 8'($urandom_range(int'(DIR_FIN) + 1, 255));
        else j_to = 8'($urandom_range(int'(DIR_INICIO), int'(DIR_FIN)));
      end

      inicio    = 1'b0;
      salto_en  = do_j;
      salto_dir = do_j ? j_to : 8'($urandom);
      bus.listo = 1'b1;
      @(negedge clk);
      salto_en  = 1'b0;
      bus.listo = rnd ? 1'($urandom % 2) : 1'b1;
      check("hs_vld_lo", 32'(bus.valido), 32'(1'b0));

      if (do_j && j_to > DIR_FIN) begin
        check("oor_err", 32'(error), 32'(1'b1));
        check("oor_ocupado", 32'(ocupado), 32'(1'b0));
        check("oor_fin", 32'(fin), 32'(1'b0));
        check("oor_dir", 32'(direccion), 32'(a));
        repeat (3) begin
          @(negedge clk);
          check("err_sticky", 32'(error), 32'(1'b1));
          check("err_idle_vld", 32'(bus.valido), 32'(1'b0));
        end
        return;
      end else if (do_j) begin
        a = j_to;
      end else if (a == DIR_FIN) begin
        check("fin_pulse", 32'(fin), 32'(1'b1));
        check("fin_ocupado", 32'(ocupado), 32'(1'b0));
        check("fin_err", 32'(error), 32'(1'b0));
        check("fin_dir", 32'(direccion), 32'(a));
        @(negedge clk);
        check("fin_one_cycle", 32'(fin), 32'(1'b0));
        check("fin_idle", 32'(ocupado), 32'(1'b0));
        return;
      end else begin
        a = a + 8'd1;
      end
      check("dir_next", 32'(direccion), 32'(a));
      check("ocupado_leer", 32'(ocupado), 32'(1'b1));
      check("fin_lo_leer", 32'(fin), 32'(1'b0));
      // inicio asserted during LEER must not restart the sequence.
      inicio = rnd ? 1'($urandom % 2) : 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom);
    bus.listo = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("reset_dir", 32'(direccion), 32'(DIR_INICIO));
    check("reset_instr", 32'(bus.instr), 32'h0);
    check("reset_vld", 32'(bus.valido), 32'(1'b0));
    check("reset_fin", 32'(fin), 32'(1'b0));
    check("reset_err", 32'(error), 32'(1'b0));
    check("reset_ocupado", 32'(ocupado), 32'(1'b0));
    repeat (3) begin
      @(negedge clk);
      check("idle_hold", 32'(ocupado), 32'(1'b0));
    end

    bus.listo = 1'b1;
    run_seq(-1, 0, -1, 0, -1, 1'b0);   // plain walk 0..10
    run_seq(3, 5, -1, 0, -1, 1'b0);    // 5-cycle stall at address 3
    run_seq(-1, 0, 5, 8, -1, 1'b0);    // jump 5 -> 8
    run_seq(-1, 0, 2, 15, -1, 1'b0);   // out-of-range jump
    run_seq(-1, 0, -1, 0, -1, 1'b0);   // restart clears error
    run_seq(-1, 0, -1, 0, 6, 1'b0);    // reset while presenting address 6
    run_seq(-1, 0, 10, 0, -1, 1'b0);   // jump on the last word
    for (int r = 0; r < 20; r++) run_seq(-1, 0, -1, 0, -1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/secuenciador_rom.md
Name: secuenciador_rom

Overview:
Address sequencer and fetch stage placed directly upstream of the 8-bit asynchronous `rom` (direccion in, dato_s out).
- Walks `direccion` from DIR_INICIO to DIR_FIN on a start command.
- Registers each ROM word and presents it to the downstream consumer with a valid/ready handshake.
- Supports an explicit jump (salto).
- Flags out-of-range jump targets so the ROM is never read outside its populated range.

Parameters:
DIR_INICIO, 8'd0, first address read after `inicio`.
DIR_FIN, 8'd10, last populated ROM address; sequence ends after this word is accepted.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  synchronous active-low reset (one clock; reset is synchronous and active-low).
inicio  input  1  start request; sampled only in REPOSO.
salto_en  input  1  jump request; sampled only on the accepting handshake cycle.
salto_dir  input  8  jump target address.
dato_s  input  8  word from rom (combinational function of `direccion`).
direccion  output  8  registered address to rom.
instr  output  8  registered ROM word delivered downstream.
valido  output  1  `instr` is valid.
listo  input  1  downstream ready.
ocupado  output  1  high in any state other than REPOSO.
fin  output  1  one-cycle pulse when the DIR_FIN word is accepted.
error  output  1  sticky; set by an out-of-range jump.

Behaviour:
- Reset (rst_n=0 at posedge): state=REPOSO, direccion=DIR_INICIO, instr=8'h00, valido=0, fin=0, error=0. Reset overrides any operation in progress, including a pending handshake.
- States: REPOSO, LEER, ENTREGA. `ocupado` = (state != REPOSO), decoded combinationally from the state register.
- REPOSO:
  - inicio=1 -> direccion<=DIR_INICIO, error<=0, go to LEER.
  - inicio=0 -> hold all outputs.
- LEER (exactly 1 cycle):
  - instr<=dato_s; valido<=1; go to ENTREGA.
  - `direccion` is stable for the whole cycle, so the ROM's combinational output is settled at the edge.
- ENTREGA:
  - valido=1; `instr` and `direccion` are held stable while listo=0, with no timeout.
  - Handshake occurs when valido & listo; on that edge valido<=0 and:
    - salto_en=1 and salto_dir<=DIR_FIN -> direccion<=salto_dir, go to LEER.
    - salto_en=1 and salto_dir>DIR_FIN -> error<=1, go to REPOSO, direccion unchanged.
    - salto_en=0 and direccion==DIR_FIN -> fin<=1 for one cycle, go to REPOSO, direccion unchanged.
    - otherwise -> direccion<=direccion+1, go to LEER.
  - Jump takes priority over end-of-range: a jump accepted on the DIR_FIN word does not raise `fin`.
- Ignored inputs:
  - inicio is ignored outside REPOSO.
  - salto_en is ignored except on the handshake edge.
- Timing:
  - Latency from inicio to first valido = 2 cycles.
  - Maximum throughput is 1 word per 2 cycles (listo held high).
  - Next valido rises 2 edges after the handshake edge.
- Arithmetic: 8-bit unsigned. No wrap can occur because the sequence stops at DIR_FIN ≤ 255. DIR_INICIO > DIR_FIN is illegal configuration (not checked).
- `fin` and `error` never assert in the same cycle. `error` stays high until the next accepted `inicio` or reset.

Test Plan:
1. Reset, then inicio pulse with listo=1 constantly -> direccion steps 0,1,…,10; `instr` equals rom[0..10] in order; 11 valido pulses, each 1 cycle wide and 2 cycles apart; fin pulses once after address 10; ocupado falls in the same cycle.
2. Backpressure: listo=0 for 5 cycles while valido=1 at address 3 -> instr=rom[3] and direccion=3 held stable all 5 cycles; on listo=1, direccion becomes 4 and the next valido follows 2 edges later.
3. Jump: at handshake of address 5, salto_en=1, salto_dir=8 -> next instr=rom[8]; the sequence continues 9, 10, then fin; addresses 6 and 7 are never presented.
4. Out-of-range jump: at handshake of address 2, salto_dir=15 -> error=1, state returns to REPOSO, valido=0, fin=0; a later inicio clears error and restarts at 0.
5. Reset mid-operation: rst_n=0 for 1 cycle while valido=1 at address 6 -> next cycle valido=0, instr=0, direccion=0, ocupado=0; inicio pulses issued during LEER/ENTREGA produce no restart.
6. Jump on last word: at handshake of address 10, salto_en=1, salto_dir=0 -> no fin; next instr=rom[0].
